// File: rtl/ysyx_25030093_pkg.sv
// Shared types and constants for the ysyx_25030093 fetch/next-PC sequencer.
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_JALR = 2'b01,
    PC_JAL  = 2'b10,
    PC_BR   = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_REQ,
    ST_RESP,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_RET         = 32'h0000_8067;

endpackage

// File: rtl/ysyx_25030093_fetch_seq_if.sv
// Instruction fetch bus: request channel (address) and response channel (data/err).
interface ysyx_25030093_fetch_seq_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        if_resp_err;
  logic        if_resp_ready;

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err
  );

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    output if_req_ready, if_resp_valid, if_resp_data, if_resp_err
  );
endinterface

// File: rtl/ysyx_25030093_fetch_seq_npc_calc.sv
// Combinational next-PC selection: sequential, jalr, jal, conditional branch.
module ysyx_25030093_npc_calc
  import ysyx_25030093_pkg::*;
(
  input  logic [31:0] pc,
  input  pc_sel_e     pc_sel,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic        br_taken,
  output logic [31:0] npc
);
  logic [31:0] seq_pc, rel_pc, jr_pc;

  assign seq_pc = pc + 32'd4;
  assign rel_pc = pc + imm;
  // jalr target has bit 0 forced low
  assign jr_pc  = (rs1 + imm) & ~32'd1;

  always_comb begin
    npc = seq_pc;
    case (pc_sel)
      PC_SEQ:  npc = seq_pc;
      PC_JALR: npc = jr_pc;
      PC_JAL:  npc = rel_pc;
      PC_BR:   npc = br_taken ? rel_pc : seq_pc;
      default: npc = seq_pc;
    endcase
  end
endmodule

// File: rtl/ysyx_25030093_fetch_seq.sv
// Handshaked fetch/next-PC sequencer owning the architectural PC.
// Optional function-trace hooks: define YSYX_25030093_FTRACE_EN.
module ysyx_25030093_fetch_seq
  import ysyx_25030093_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  ysyx_25030093_fetch_seq_if.master        bus,
  output logic [31:0]                      inst,
  output logic                             inst_valid,
  input  logic                             exu_done,
  input  logic [1:0]                       pc_sel,
  input  logic [31:0]                      rs1_data,
  input  logic [31:0]                      imm_data,
  input  logic                             br_taken,
  input  logic                             halt,
  output logic [31:0]                      pc,
  output logic                             fetch_err,
  output logic                             halted
);
  state_e      state, state_nx;
  logic [31:0] npc;
  logic        req_valid, resp_ready;
  logic        commit, resp_ok, resp_bad, stall, tmo;

  ysyx_25030093_npc_calc u_npc (
    .pc       (pc),
    .pc_sel   (pc_sel_e'(pc_sel)),
    .rs1      (rs1_data),
    .imm      (imm_data),
    .br_taken (br_taken),
    .npc      (npc)
  );

  assign commit   = (state == ST_EXEC) && exu_done;
  assign resp_ok  = (state == ST_RESP) && bus.if_resp_valid && !bus.if_resp_err;
  assign resp_bad = (state == ST_RESP) && bus.if_resp_valid &&  bus.if_resp_err;
  assign stall    = ((state == ST_REQ)  && !bus.if_req_ready) ||
                    ((state == ST_RESP) && !bus.if_resp_valid);

  // Bus watchdog: counts consecutive stalled REQ/RESP cycles.
  generate
    if (TIMEOUT_CYCLES != 0) begin : g_tmo
      localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
      logic [TW-1:0] tcnt;

      assign tmo = stall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             tcnt <= '0;
        else if (!stall || tmo) tcnt <= '0;
        else                    tcnt <= tcnt + TW'(1);
      end
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_RESET: state_nx = ST_REQ;
      ST_REQ: begin
        if (tmo)                    state_nx = ST_HALT;
        else if (bus.if_req_ready)  state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (bus.if_resp_valid)      state_nx = bus.if_resp_err ? ST_HALT : ST_EXEC;
        else if (tmo)               state_nx = ST_HALT;
      end
      ST_EXEC: begin
        if (exu_done)               state_nx = halt ? ST_HALT : ST_REQ;
      end
      ST_HALT:                      state_nx = ST_HALT;
      default:                      state_nx = ST_RESET;
    endcase
  end

  always_comb begin
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    inst_valid = 1'b0;
    halted     = 1'b0;
    case (state)
      ST_REQ:  req_valid  = 1'b1;
      ST_RESP: resp_ready = 1'b1;
      ST_EXEC: inst_valid = 1'b1;
      ST_HALT: halted     = 1'b1;
      default: ;
    endcase
  end

  assign bus.if_req_valid  = req_valid;
  assign bus.if_req_addr   = pc;
  assign bus.if_resp_ready = resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (commit)          pc        <= npc;
      if (resp_ok)         inst      <= bus.if_resp_data;
      if (resp_bad || tmo) fetch_err <= 1'b1;
    end
  end

`ifdef YSYX_25030093_FTRACE_EN
  // Trace on the committing edge; ret is jalr with the canonical encoding.
  always @(posedge clk) begin
    if (rst_n && commit) begin
      if (pc_sel_e'(pc_sel) == PC_JALR && inst == INST_RET)
        $display("ftrace ret  pc=%h", pc);
      else if (pc_sel_e'(pc_sel) == PC_JALR || pc_sel_e'(pc_sel) == PC_JAL)
        $display("ftrace call pc=%h target=%h", pc, npc);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25030093_fetch_seq.sv
// Directed bench: expected fetch addresses are queued at each commit and popped on the next request.
module tb_ysyx_25030093_fetch_seq;
  import ysyx_25030093_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ysyx_25030093_fetch_seq_if bus();

  logic [31:0] inst, rs1_data, imm_data, pc;
  logic        inst_valid, exu_done, br_taken, halt, fetch_err, halted;
  logic [1:0]  pc_sel;

  ysyx_25030093_fetch_seq #(
    .RESET_PC       (32'h8000_0000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .inst       (inst),
    .inst_valid (inst_valid),
    .exu_done   (exu_done),
    .pc_sel     (pc_sel),
    .rs1_data   (rs1_data),
    .imm_data   (imm_data),
    .br_taken   (br_taken),
    .halt       (halt),
    .pc         (pc),
    .fetch_err  (fetch_err),
    .halted     (halted)
  );

  int          nchk = 0;
  int          npass = 0;
  int          cyc = 0;
  int          last_req_cyc = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, compare address with the scoreboard head.
  task automatic wait_req(input int exp_gap, output logic [31:0] a);
    int n = 0;
    while (!bus.if_req_valid && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'b0, bus.if_req_valid}, 32'd1);
    a = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk("req_addr", bus.if_req_addr, a);
    chk("pc", pc, a);
    if (exp_gap > 0) chk("req_gap", 32'(cyc - last_req_cyc), 32'(exp_gap));
    last_req_cyc = cyc;
  endtask

  task automatic fetch(input logic [31:0] data, input int req_dly, input int resp_dly,
                       input bit glitch, input int exp_gap);
    logic [31:0] a;
    wait_req(exp_gap, a);
    for (int i = 0; i < req_dly; i++) begin
      if (glitch && i == 0) begin
        bus.if_resp_valid = 1'b1;
        bus.if_resp_data  = 32'hBAD0_0BAD;
      end
      step();
      bus.if_resp_valid = 1'b0;
      chk("req_hold_valid", {31'b0, bus.if_req_valid}, 32'd1);
      chk("req_hold_addr", bus.if_req_addr, a);
    end
    bus.if_req_ready = 1'b1;
    step();
    bus.if_req_ready = 1'b0;
    chk("resp_ready", {31'b0, bus.if_resp_ready}, 32'd1);
    chk("req_drop", {31'b0, bus.if_req_valid}, 32'd0);
    for (int i = 0; i < resp_dly; i++) begin
      if (glitch) exu_done = 1'b1;
      step();
      exu_done = 1'b0;
      chk("resp_wait", {30'b0, inst_valid, bus.if_resp_ready}, 32'd1);
    end
    if (glitch) chk("pc_hold", pc, a);
    bus.if_resp_valid = 1'b1;
    bus.if_resp_data  = data;
    step();
    bus.if_resp_valid = 1'b0;
    bus.if_resp_data  = '0;
    chk("inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("inst", inst, data);
  endtask

  // One idle EXEC cycle, then exu_done with the given next-PC inputs.
  task automatic exec(input logic [1:0] sel, input logic [31:0] rs1, input logic [31:0] imm,
                      input bit br, input bit hlt, input logic [31:0] exp_npc);
    step();
    chk("exec_hold", {31'b0, inst_valid}, 32'd1);
    pc_sel = sel; rs1_data = rs1; imm_data = imm; br_taken = br; halt = hlt;
    exu_done = 1'b1;
    if (!hlt) exp_q.push_back(exp_npc);
    step();
    exu_done = 1'b0; halt = 1'b0; pc_sel = 2'b00; br_taken = 1'b0;
    chk("inst_valid_drop", {31'b0, inst_valid}, 32'd0);
    chk("npc", pc, exp_npc);
  endtask

  task automatic release_reset();
    step();
    rst_n = 1'b1;
    chk("idle_cycle", {31'b0, bus.if_req_valid}, 32'd0);
    exp_q.delete();
    exp_q.push_back(32'h8000_0000);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    release_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int n;
    bus.if_req_ready = 1'b0; bus.if_resp_valid = 1'b0;
    bus.if_resp_data = '0;   bus.if_resp_err = 1'b0;
    exu_done = 1'b0; pc_sel = 2'b00; rs1_data = '0; imm_data = '0;
    br_taken = 1'b0; halt = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_outs", {26'b0, bus.if_req_valid, bus.if_resp_ready, inst_valid, fetch_err, halted, 1'b0}, 32'h0);
    release_reset();

    // zero-wait sequential fetch, 4 cycles per instruction
    fetch(32'h0000_0013, 0, 0, 1'b0, 0);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0004);
    fetch(32'h0000_0013, 0, 0, 1'b0, 4);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0008);
    fetch(32'h0000_0013, 0, 0, 1'b0, 4);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_000C);
    fetch(32'h0000_0013, 0, 0, 1'b0, 4);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0010);

    // jalr ret with odd target, jal backwards, branch taken/not taken
    fetch(INST_RET, 0, 0, 1'b0, 4);
    exec(2'b01, 32'h8000_0101, 32'h4, 1'b0, 1'b0, 32'h8000_0104);
    fetch(32'h0000_006F, 0, 0, 1'b0, 4);
    exec(2'b10, 32'h0, 32'hFFFF_FF1C, 1'b0, 1'b0, 32'h8000_0020);
    fetch(32'hFE00_0CE3, 0, 0, 1'b0, 4);
    exec(2'b11, 32'h0, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h8000_0018);
    fetch(32'h0080_006F, 0, 0, 1'b0, 4);
    exec(2'b10, 32'h0, 32'h8, 1'b0, 1'b0, 32'h8000_0020);
    fetch(32'hFE00_0CE3, 0, 0, 1'b0, 4);
    exec(2'b11, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b0, 32'h8000_0024);

    // stalled request and response with stray resp_valid/exu_done
    fetch(32'h1234_5678, 3, 5, 1'b1, 4);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0028);
    fetch(32'h0180_006F, 0, 0, 1'b0, 0);
    exec(2'b10, 32'h0, 32'h18, 1'b0, 1'b0, 32'h8000_0040);

    // halt on commit: pc advances once then freezes
    fetch(32'h0010_0073, 0, 0, 1'b0, 4);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0044);
    chk("halted", {31'b0, halted}, 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      bus.if_req_ready = 1'b1; exu_done = 1'b1;
      step();
      if (bus.if_req_valid || bus.if_resp_ready || inst_valid) n++;
    end
    bus.if_req_ready = 1'b0; exu_done = 1'b0;
    chk("halt_quiet", 32'(n), 32'd0);
    chk("halt_pc", pc, 32'h8000_0044);
    chk("halt_no_err", {31'b0, fetch_err}, 32'd0);

    // async reset in the middle of RESP
    pulse_reset();
    fetch(32'h0000_0013, 0, 0, 1'b0, 0);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0004);
    wait_req(4, a);
    bus.if_req_ready = 1'b1;
    step();
    bus.if_req_ready = 1'b0;
    chk("mid_resp_ready", {31'b0, bus.if_resp_ready}, 32'd1);
    #3 rst_n = 1'b0;
    bus.if_resp_valid = 1'b1; bus.if_resp_data = 32'hCAFE_F00D;
    #1;
    chk("async_pc", pc, 32'h8000_0000);
    chk("async_outs", {29'b0, bus.if_resp_ready, bus.if_req_valid, halted}, 32'h0);
    @(posedge clk); #1;
    bus.if_resp_valid = 1'b0; bus.if_resp_data = '0;
    rst_n = 1'b1;
    chk("post_rst_idle", {31'b0, bus.if_req_valid}, 32'd0);
    exp_q.delete();
    exp_q.push_back(32'h8000_0000);
    fetch(32'h0000_0093, 0, 0, 1'b0, 0);
    exec(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0004);

    // bus error on response
    pulse_reset();
    wait_req(0, a);
    bus.if_req_ready = 1'b1;
    step();
    bus.if_req_ready = 1'b0;
    bus.if_resp_valid = 1'b1; bus.if_resp_err = 1'b1; bus.if_resp_data = 32'h0000_0013;
    step();
    bus.if_resp_valid = 1'b0; bus.if_resp_err = 1'b0; bus.if_resp_data = '0;
    chk("err_flags", {30'b0, fetch_err, halted}, 32'd3);
    chk("err_no_inst", {31'b0, inst_valid}, 32'd0);
    chk("err_inst_kept", inst, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.if_req_valid) n++;
    end
    chk("err_no_req", 32'(n), 32'd0);

    // request never accepted -> timeout after 8 stalled cycles
    pulse_reset();
    wait_req(0, a);
    n = 0;
    while (!fetch_err && n < 30) begin
      step();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd8);
    chk("tmo_halted", {31'b0, halted}, 32'd1);
    chk("tmo_req_drop", {31'b0, bus.if_req_valid}, 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
